// File: rtl/usb_pkg.sv
// Shared packet, state and default-timing definitions for the USB bulk endpoint controller.
package usb_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 128;

    typedef enum logic [2:0] {
        RX_NONE  = 3'd0,
        RX_OUT   = 3'd1,
        RX_IN    = 3'd2,
        RX_DATA0 = 3'd3,
        RX_DATA1 = 3'd4,
        RX_ACK   = 3'd5,
        RX_NAK   = 3'd6
    } rx_packet_t;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4
    } tx_packet_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OUT_WAIT,
        S_OUT_ACK,
        S_OUT_NAK,
        S_IN_DATA,
        S_IN_WAIT_ACK,
        S_IN_NAK,
        S_TX_WAIT,
        S_FLUSH
    } ctrl_state_t;

    function automatic logic is_data_pid(input rx_packet_t p);
        return (p == RX_DATA0) || (p == RX_DATA1);
    endfunction

endpackage

// File: rtl/usb_timeout_timer.sv
// Saturating response timer: cleared by i_clr, counts while i_en, flags the last count.
module usb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_terminal
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Holds at LAST so a late clear never sees a wrapped count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = i_en && !i_clr && (r_count == LAST);

endmodule

// File: rtl/usb_bulk_ctrl.sv
// USB bulk endpoint sequencer: OUT/IN handshakes, buffer commit/flush, response timeout.
// Build option: define USB_CTRL_TOGGLE_EN to enable DATA0/DATA1 toggle checking and tracking.
module usb_bulk_ctrl
    import usb_pkg::*;
#(
    parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int  BUF_DEPTH      = 64,
    localparam int OCC_W          = $clog2(BUF_DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rx_packet_valid,
    input  rx_packet_t       i_rx_packet,
    input  logic             i_rx_error,
    input  logic [OCC_W-1:0] i_buffer_occupancy,
    input  logic             i_in_ready,
    input  logic             i_tx_done,
    output logic             o_tx_start,
    output tx_packet_t       o_tx_packet,
    output logic             o_d_mode,
    output logic             o_rx_write_en,
    output logic             o_commit,
    output logic             o_flush,
    output logic             o_in_consume,
    output logic             o_timeout
);

    ctrl_state_t r_state;
    tx_packet_t  r_tx_packet;
    logic        r_nak_pending;
    logic        r_tx_start;
    logic        r_d_mode;
    logic        r_rx_write_en;
    logic        r_commit;
    logic        r_flush;
    logic        r_in_consume;

    logic        w_rx_ok;
    logic        w_rx_data;
    logic        w_tmr_en;
    logic        w_tmo;
    logic        w_data_match;
    logic        w_in_ack;
    tx_packet_t  w_in_pid;

    assign w_rx_ok   = i_rx_packet_valid && !i_rx_error;
    assign w_rx_data = w_rx_ok && is_data_pid(i_rx_packet);
    assign w_tmr_en  = (r_state == S_OUT_WAIT) || (r_state == S_IN_WAIT_ACK);
    assign w_in_ack  = (r_state == S_IN_WAIT_ACK) && w_rx_ok && (i_rx_packet == RX_ACK);

`ifdef USB_CTRL_TOGGLE_EN
    logic r_tog_out;
    logic r_tog_in;
    logic w_out_accept;

    assign w_data_match = ((i_rx_packet == RX_DATA1) == r_tog_out);
    assign w_in_pid     = r_tog_in ? TX_DATA1 : TX_DATA0;
    assign w_out_accept = (r_state == S_OUT_WAIT) && w_rx_data && !r_nak_pending && w_data_match;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tog_out <= 1'b0;
            r_tog_in  <= 1'b0;
        end else begin
            if (w_out_accept) r_tog_out <= ~r_tog_out;
            if (w_in_ack)     r_tog_in  <= ~r_tog_in;
        end
    end
`else
    assign w_data_match = 1'b1;
    assign w_in_pid     = TX_DATA0;
`endif

    usb_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (!w_tmr_en),
        .i_en      (w_tmr_en),
        .o_terminal(w_tmo)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_tx_packet   <= TX_NONE;
            r_nak_pending <= 1'b0;
            r_tx_start    <= 1'b0;
            r_d_mode      <= 1'b0;
            r_rx_write_en <= 1'b0;
            r_commit      <= 1'b0;
            r_flush       <= 1'b0;
            r_in_consume  <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_commit     <= 1'b0;
            r_flush      <= 1'b0;
            r_in_consume <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rx_ok && (i_rx_packet == RX_OUT)) begin
                        r_state       <= S_OUT_WAIT;
                        r_nak_pending <= (i_buffer_occupancy != '0);
                        r_rx_write_en <= (i_buffer_occupancy == '0);
                    end else if (w_rx_ok && (i_rx_packet == RX_IN)) begin
                        r_tx_start <= 1'b1;
                        r_d_mode   <= 1'b1;
                        if (i_in_ready && (i_buffer_occupancy != '0)) begin
                            r_state     <= S_IN_DATA;
                            r_tx_packet <= w_in_pid;
                        end else begin
                            r_state     <= S_IN_NAK;
                            r_tx_packet <= TX_NAK;
                        end
                    end
                end
                S_OUT_WAIT: begin
                    if (w_rx_data) begin
                        r_rx_write_en <= 1'b0;
                        r_tx_start    <= 1'b1;
                        r_d_mode      <= 1'b1;
                        if (r_nak_pending) begin
                            r_state     <= S_OUT_NAK;
                            r_tx_packet <= TX_NAK;
                            r_flush     <= 1'b1;
                        end else begin
                            // A toggle mismatch is a retried packet already committed: ACK it, drop the bytes.
                            r_state     <= S_OUT_ACK;
                            r_tx_packet <= TX_ACK;
                            r_commit    <= w_data_match;
                            r_flush     <= !w_data_match;
                        end
                    end else if (i_rx_error || i_rx_packet_valid || w_tmo) begin
                        r_rx_write_en <= 1'b0;
                        r_state       <= S_FLUSH;
                        r_flush       <= 1'b1;
                    end
                end
                S_OUT_ACK, S_OUT_NAK, S_IN_NAK, S_IN_DATA: begin
                    r_state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (i_tx_done) begin
                        r_d_mode    <= 1'b0;
                        r_tx_packet <= TX_NONE;
                        r_state     <= ((r_tx_packet == TX_DATA0) || (r_tx_packet == TX_DATA1))
                                       ? S_IN_WAIT_ACK : S_IDLE;
                    end
                end
                S_IN_WAIT_ACK: begin
                    if (w_in_ack) begin
                        r_in_consume <= 1'b1;
                        r_state      <= S_IDLE;
                    end else if (i_rx_error || i_rx_packet_valid || w_tmo) begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_tx_packet   <= TX_NONE;
                    r_d_mode      <= 1'b0;
                    r_rx_write_en <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx_start    = r_tx_start;
    assign o_tx_packet   = r_tx_packet;
    assign o_d_mode      = r_d_mode;
    assign o_rx_write_en = r_rx_write_en;
    assign o_commit      = r_commit;
    assign o_flush       = r_flush;
    assign o_in_consume  = r_in_consume;
    assign o_timeout     = w_tmo;

endmodule

// File: tb/tb_usb_bulk_ctrl.sv
// Scoreboard bench for usb_bulk_ctrl: expected output pulses are queued with their cycle stamp.
module tb_usb_bulk_ctrl;
    import usb_pkg::*;

    localparam int TMO = 128;
`ifdef USB_CTRL_TOGGLE_EN
    localparam bit TOG = 1'b1;
`else
    localparam bit TOG = 1'b0;
`endif
    localparam logic [3:0] K_TX  = 4'd1;
    localparam logic [3:0] K_CMT = 4'd2;
    localparam logic [3:0] K_FLS = 4'd3;
    localparam logic [3:0] K_CNS = 4'd4;
    localparam logic [3:0] K_TMO = 4'd5;
    localparam int R_ACK = 0, R_NAK = 1, R_ERR = 2, R_NONE = 3;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       rx_valid = 1'b0;
    rx_packet_t rx_pkt   = RX_NONE;
    logic       rx_error = 1'b0;
    logic [6:0] occ      = 7'd0;
    logic       in_ready = 1'b0;
    logic       tx_done  = 1'b0;

    logic       o_tx_start, o_d_mode, o_rx_write_en, o_commit, o_flush, o_in_consume, o_timeout;
    tx_packet_t o_tx_packet;

    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        m_tog_out = 1'b0;
    logic        m_tog_in  = 1'b0;
    logic [23:0] exp_q[$];

    usb_bulk_ctrl dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_rx_packet_valid (rx_valid),
        .i_rx_packet       (rx_pkt),
        .i_rx_error        (rx_error),
        .i_buffer_occupancy(occ),
        .i_in_ready        (in_ready),
        .i_tx_done         (tx_done),
        .o_tx_start        (o_tx_start),
        .o_tx_packet       (o_tx_packet),
        .o_d_mode          (o_d_mode),
        .o_rx_write_en     (o_rx_write_en),
        .o_commit          (o_commit),
        .o_flush           (o_flush),
        .o_in_consume      (o_in_consume),
        .o_timeout         (o_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] k, input logic [3:0] v);
        exp_q.push_back({c[15:0], k, v});
    endtask

    task automatic push_tx(input tx_packet_t p);
        push_ev(cyc + 1, K_TX, {1'b0, p});
    endtask

    task automatic sb_take(input logic [3:0] k, input logic [3:0] v);
        logic [23:0] obs;
        obs = {cyc[15:0], k, v};
        if (exp_q.size() == 0) check_eq("sb_unexpected", 32'(obs), 32'd0);
        else                   check_eq("sb_event", 32'(obs), 32'(exp_q.pop_front()));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (o_tx_start)   sb_take(K_TX, {1'b0, o_tx_packet});
            if (o_commit)     sb_take(K_CMT, 4'd0);
            if (o_flush)      sb_take(K_FLS, 4'd0);
            if (o_in_consume) sb_take(K_CNS, 4'd0);
            if (o_timeout)    sb_take(K_TMO, 4'd0);
        end
    end

    task automatic step();
        @(negedge clk);
        rx_valid = 1'b0;
        rx_error = 1'b0;
        tx_done  = 1'b0;
        rx_pkt   = RX_NONE;
    endtask

    task automatic out_txn(input logic [6:0] o, input rx_packet_t d);
        tx_packet_t pid;
        occ = o; rx_valid = 1'b1; rx_pkt = RX_OUT;
        step();
        check_eq("out_wait_wr_en", 32'(o_rx_write_en), 32'(o == 7'd0));
        check_eq("out_wait_dmode", 32'(o_d_mode), 32'd0);
        rx_valid = 1'b1; rx_pkt = d;
        if (o != 7'd0) begin
            pid = TX_NAK;
            push_tx(TX_NAK); push_ev(cyc + 1, K_FLS, 4'd0);
        end else if (!TOG || ((d == RX_DATA1) == m_tog_out)) begin
            pid = TX_ACK;
            push_tx(TX_ACK); push_ev(cyc + 1, K_CMT, 4'd0);
            if (TOG) m_tog_out = ~m_tog_out;
        end else begin
            pid = TX_ACK;
            push_tx(TX_ACK); push_ev(cyc + 1, K_FLS, 4'd0);
        end
        step();
        check_eq("out_resp_wr_en", 32'(o_rx_write_en), 32'd0);
        check_eq("out_resp_dmode", 32'(o_d_mode), 32'd1);
        step();
        check_eq("out_hold_pid", 32'(o_tx_packet), 32'(pid));
        check_eq("out_hold_dmode", 32'(o_d_mode), 32'd1);
        tx_done = 1'b1;
        step();
        check_eq("out_end_dmode", 32'(o_d_mode), 32'd0);
        check_eq("out_end_pid", 32'(o_tx_packet), 32'(TX_NONE));
    endtask

    task automatic in_txn(input logic rdy, input logic [6:0] o, input int resp);
        tx_packet_t pid;
        logic       is_data;
        in_ready = rdy; occ = o; rx_valid = 1'b1; rx_pkt = RX_IN;
        is_data = rdy && (o != 7'd0);
        pid = !is_data ? TX_NAK : ((TOG && m_tog_in) ? TX_DATA1 : TX_DATA0);
        push_tx(pid);
        step();
        check_eq("in_start_dmode", 32'(o_d_mode), 32'd1);
        step();
        check_eq("in_hold_pid", 32'(o_tx_packet), 32'(pid));
        tx_done = 1'b1;
        step();
        check_eq("in_end_dmode", 32'(o_d_mode), 32'd0);
        if (is_data) begin
            case (resp)
                R_ACK: begin
                    rx_valid = 1'b1; rx_pkt = RX_ACK;
                    push_ev(cyc + 1, K_CNS, 4'd0);
                    if (TOG) m_tog_in = ~m_tog_in;
                    step(); step();
                end
                R_NAK: begin
                    rx_valid = 1'b1; rx_pkt = RX_NAK;
                    step(); step();
                end
                R_ERR: begin
                    rx_error = 1'b1; rx_valid = 1'b1; rx_pkt = RX_ACK;
                    step(); step();
                end
                default: begin
                    push_ev(cyc + TMO - 1, K_TMO, 4'd0);
                    repeat (TMO + 8) step();
                end
            endcase
        end
    endtask

    task automatic out_abort(input int mode);
        occ = 7'd0; rx_valid = 1'b1; rx_pkt = RX_OUT;
        step();
        case (mode)
            0: begin rx_error = 1'b1; push_ev(cyc + 1, K_FLS, 4'd0); step(); end
            1: begin
                rx_error = 1'b1; rx_valid = 1'b1; rx_pkt = RX_DATA0;
                push_ev(cyc + 1, K_FLS, 4'd0); step();
            end
            2: begin rx_valid = 1'b1; rx_pkt = RX_IN; push_ev(cyc + 1, K_FLS, 4'd0); step(); end
            default: begin
                push_ev(cyc + TMO - 1, K_TMO, 4'd0);
                push_ev(cyc + TMO, K_FLS, 4'd0);
                repeat (64) step();
                check_eq("out_tmo_wr_en_mid", 32'(o_rx_write_en), 32'd1);
                repeat (TMO - 64 + 6) step();
            end
        endcase
        step();
        check_eq("abort_idle_wr_en", 32'(o_rx_write_en), 32'd0);
        check_eq("abort_idle_dmode", 32'(o_d_mode), 32'd0);
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({o_tx_start, o_tx_packet, o_d_mode, o_rx_write_en,
                    o_commit, o_flush, o_in_consume, o_timeout});
    endfunction

    initial begin
        @(negedge clk);
        check_eq("reset_outputs", out_vec(), 32'd0);
        rst = 1'b0;
        step();

        out_txn(7'd0, RX_DATA0);
        out_txn(7'd0, RX_DATA0);
        out_txn(7'd10, RX_DATA1);
        out_txn(7'd0, RX_DATA1);

        in_txn(1'b1, 7'd8, R_ACK);
        in_txn(1'b1, 7'd8, R_NONE);
        in_txn(1'b1, 7'd8, R_NAK);
        in_txn(1'b1, 7'd8, R_ERR);
        in_txn(1'b0, 7'd8, R_ACK);
        in_txn(1'b1, 7'd0, R_ACK);

        out_abort(0);
        out_abort(1);
        out_abort(2);
        out_abort(3);

        rx_valid = 1'b1; rx_pkt = RX_DATA0; step();
        rx_valid = 1'b1; rx_pkt = RX_ACK;   step();
        rx_error = 1'b1; rx_valid = 1'b1; rx_pkt = RX_OUT; step();
        step();
        check_eq("idle_ignore_wr_en", 32'(o_rx_write_en), 32'd0);
        check_eq("idle_ignore_dmode", 32'(o_d_mode), 32'd0);

        out_txn(7'd0, TOG && m_tog_out ? RX_DATA1 : RX_DATA0);

        in_ready = 1'b1; occ = 7'd8; rx_valid = 1'b1; rx_pkt = RX_IN;
        push_tx((TOG && m_tog_in) ? TX_DATA1 : TX_DATA0);
        step();
        step();
        check_eq("pre_reset_dmode", 32'(o_d_mode), 32'd1);
        #2 rst = 1'b1;
        #1 check_eq("async_reset_outputs", out_vec(), 32'd0);
        m_tog_out = 1'b0;
        m_tog_in  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        in_txn(1'b1, 7'd8, R_ACK);
        out_txn(7'd0, RX_DATA1);
        out_txn(7'd0, RX_DATA0);

        repeat (5) step();
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end, got t=%0t, want earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
